// File: rtl/riscv_pkg.sv
// RV32M shared constants: funct7/funct3 encodings and the mul/div sequencer state enum.
// Latency: none (declarations only).
// Backpressure: not applicable.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP  = 7'b0110011;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdState_t;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Latency: doneM XLEN+2 cycles after start; divide-by-zero and signed overflow finish in 1 cycle.
// Backpressure: stalls the pipeline via busyE while iterating; flushE aborts in any state.
module muldiv_seq
  import riscv_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int CNTW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startE,
  input  logic            flushE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  input  logic [4:0]      rdE,
  output logic            busyE,
  output logic            doneM,
  output logic [XLEN-1:0] resultM,
  output logic [4:0]      rdM
);

  mdState_t          state;
  logic [2:0]        opR;
  logic [4:0]        rdR;
  logic              negR;
  logic [XLEN-1:0]   opndR;
  logic [2*XLEN-1:0] prodR;
  logic [XLEN:0]     remR;
  logic [CNTW-1:0]   cnt;
  logic [XLEN-1:0]   resultQ;
  logic [4:0]        rdQ;
  logic              doneQ;

  // Operand decode at start: signedness, magnitudes, final result sign, short-circuit cases.
  logic            isDiv, aSigned, bSigned, aNeg, bNeg, negStart;
  logic            divZero, divOvf, special;
  logic [XLEN-1:0] aMag, bMag, specialRes;

  always_comb begin
    isDiv    = funct3E[2];
    aSigned  = isDiv ? !funct3E[0] : (funct3E != F3_MULHU);
    bSigned  = isDiv ? !funct3E[0] : !funct3E[1];
    aNeg     = aSigned & srcAE[XLEN-1];
    bNeg     = bSigned & srcBE[XLEN-1];
    aMag     = aNeg ? -srcAE : srcAE;
    bMag     = bNeg ? -srcBE : srcBE;
    negStart = (isDiv && funct3E[1]) ? aNeg : (aNeg ^ bNeg);
    divZero  = isDiv && (srcBE == '0);
    divOvf   = isDiv && !funct3E[0] && (srcAE == {1'b1, {(XLEN-1){1'b0}}}) && (srcBE == '1);
    special  = divZero || divOvf;
    if (divZero) specialRes = funct3E[1] ? srcAE : '1;
    else         specialRes = funct3E[1] ? '0 : srcAE;
  end

  // One iteration step; the divide reuses prodR[XLEN-1:0] as dividend-in / quotient-out.
  logic [XLEN:0]     mulSum, divShift, divDiff;
  logic              divFits;
  logic [2*XLEN-1:0] prodNeg;
  logic [XLEN-1:0]   quot, remv, fixRes;

  always_comb begin
    mulSum   = {1'b0, prodR[2*XLEN-1:XLEN]} + (prodR[0] ? {1'b0, opndR} : '0);
    divShift = {remR[XLEN-1:0], prodR[XLEN-1]};
    divDiff  = divShift - {1'b0, opndR};
    divFits  = divShift >= {1'b0, opndR};
    prodNeg  = negR ? -prodR : prodR;
    quot     = negR ? -prodR[XLEN-1:0] : prodR[XLEN-1:0];
    remv     = negR ? -remR[XLEN-1:0] : remR[XLEN-1:0];
    fixRes   = '0;
    case (opR)
      F3_MUL:                       fixRes = prodNeg[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fixRes = prodNeg[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fixRes = quot;
      F3_REM, F3_REMU:              fixRes = remv;
      default:                      fixRes = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      opR     <= '0;
      rdR     <= '0;
      negR    <= 1'b0;
      opndR   <= '0;
      prodR   <= '0;
      remR    <= '0;
      cnt     <= '0;
      resultQ <= '0;
      rdQ     <= '0;
      doneQ   <= 1'b0;
    end else if (flushE) begin
      state <= IDLE;
      doneQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          doneQ <= 1'b0;
          if (startE) begin
            opR  <= funct3E;
            rdR  <= rdE;
            negR <= negStart;
            if (special) begin
              resultQ <= specialRes;
              rdQ     <= rdE;
              doneQ   <= 1'b1;
              state   <= DONE;
            end else begin
              cnt   <= '0;
              remR  <= '0;
              opndR <= isDiv ? bMag : aMag;
              prodR <= {{XLEN{1'b0}}, (isDiv ? aMag : bMag)};
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (opR[2]) begin
            remR               <= divFits ? divDiff : divShift;
            prodR[XLEN-1:0]    <= {prodR[XLEN-2:0], divFits};
          end else begin
            prodR <= {mulSum, prodR[XLEN-1:1]};
          end
          cnt <= cnt + CNTW'(1);
          if (cnt == CNTW'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          resultQ <= fixRes;
          rdQ     <= rdR;
          doneQ   <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          doneQ <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busyE   = (state == IDLE && startE && !flushE) || state == CALC || state == FIX;
  assign doneM   = doneQ && !flushE;
  assign resultM = resultQ;
  assign rdM     = rdQ;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed RV32M results, latency, stall and abort behaviour.
module tb_muldiv_seq;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startE = 1'b0;
  logic        flushE = 1'b0;
  logic [2:0]  funct3E = '0;
  logic [31:0] srcAE = '0;
  logic [31:0] srcBE = '0;
  logic [4:0]  rdE = '0;
  logic        busyE, doneM;
  logic [31:0] resultM;
  logic [4:0]  rdM;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .startE(startE), .flushE(flushE),
    .funct3E(funct3E), .srcAE(srcAE), .srcBE(srcBE), .rdE(rdE),
    .busyE(busyE), .doneM(doneM), .resultM(resultM), .rdM(rdM)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; that cycle becomes cycle 0 of the op.
  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] expRes, input int expLat);
    int  t0;
    int  doneAt;
    bit  busyOk;
    t0 = cyc;
    startE = 1'b1; funct3E = f3; srcAE = a; srcBE = b; rdE = rd;
    #1 busyOk = (busyE === 1'b1);
    doneAt = -1;
    for (int i = 0; i < 100 && doneAt < 0; i++) begin
      @(posedge clk); #1;
      startE = 1'b0;
      if (doneM === 1'b1) begin
        doneAt = cyc - t0;
        if (busyE !== 1'b0) busyOk = 0;
      end else if (busyE !== 1'b1) begin
        busyOk = 0;
      end
    end
    chk({tag, " latency"}, doneAt, expLat);
    chk({tag, " result"}, resultM, expRes);
    chk({tag, " rd"}, rdM, rd);
    chk({tag, " busy"}, busyOk, 1);
    @(posedge clk); #1;
    chk({tag, " done pulse width"}, doneM, 0);
  endtask

  initial begin
    int  t0;
    bit  sawDone;

    // Reset state
    #2;
    chk("reset busyE", busyE, 0);
    chk("reset doneM", doneM, 0);
    chk("reset resultM", resultM, 0);
    chk("reset rdM", rdM, 0);
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;

    // Multiply family
    runOp("MUL 7*-3",        F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34);
    runOp("MULHU -1*-1",     F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 34);
    runOp("MULH -1*-1",      F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 34);
    runOp("MULHSU -1*2",     F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 34);

    // Divide family
    runOp("DIV -7/2",        F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34);
    runOp("REM -7%2",        F3_REM,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34);
    runOp("DIVU 100/7",      F3_DIVU,   32'd100,      32'd7,        5'd11, 32'd14,       34);
    runOp("REMU 100%7",      F3_REMU,   32'd100,      32'd7,        5'd12, 32'd2,        34);

    // Short-circuit cases
    runOp("DIV 5/0",         F3_DIV,    32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
    runOp("REM 5%0",         F3_REM,    32'd5,        32'd0,        5'd14, 32'd5,        1);
    runOp("REM ovf",         F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1);
    runOp("DIV ovf",         F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);

    // Flush in cycle 10 of a DIV, then a MUL started in cycle 11
    t0 = cyc;
    sawDone = 0;
    startE = 1'b1; funct3E = F3_DIV; srcAE = 32'd1000; srcBE = 32'd3; rdE = 5'd20;
    @(posedge clk); #1;
    startE = 1'b0;
    while (cyc - t0 < 10) begin
      if (doneM === 1'b1) sawDone = 1;
      @(posedge clk); #1;
    end
    flushE = 1'b1;
    @(posedge clk); #1;
    flushE = 1'b0;
    chk("flush cycle index", cyc - t0, 11);
    chk("flush state", dut.state, IDLE);
    chk("flush busyE", busyE, 0);
    chk("flush no done", sawDone | doneM, 0);
    runOp("MUL after flush", F3_MUL, 32'd6, 32'd7, 5'd21, 32'd42, 34);
    chk("flush+MUL done cycle", cyc - t0, 46);

    // Flush landing in the DONE cycle hides the pulse
    startE = 1'b1; funct3E = F3_DIVU; srcAE = 32'd9; srcBE = 32'd0; rdE = 5'd22;
    @(posedge clk); #1;
    startE = 1'b0;
    flushE = 1'b1;
    #1 chk("flush in DONE doneM", doneM, 0);
    @(posedge clk); #1;
    flushE = 1'b0;
    chk("flush in DONE state", dut.state, IDLE);

    // Asynchronous reset mid-CALC
    @(posedge clk); #1;
    startE = 1'b1; funct3E = F3_MUL; srcAE = 32'd1234; srcBE = 32'd5678; rdE = 5'd23;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async reset busyE", busyE, 0);
    chk("async reset doneM", doneM, 0);
    chk("async reset resultM", resultM, 0);
    chk("async reset rdM", rdM, 0);
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    runOp("MUL 3*4 post-reset", F3_MUL, 32'd3, 32'd4, 5'd24, 32'd12, 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
